// File: rtl/boot_sequencer.sv
// Holds the core in reset, releases it with a one-cycle start pulse at the entry address,
// then ends the run on a PC halt loop or a cycle budget and reports status.
module boot_sequencer #(
    parameter int ADDRESS_BITS   = 32,
    parameter int RESET_CYCLES   = 4,
    parameter int HALT_REPEAT    = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int COUNT_BITS     = 32
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    go_i,
    input  logic [ADDRESS_BITS-1:0] entry_address_i,
    output logic                    core_reset_o,
    output logic                    core_start_o,
    output logic [ADDRESS_BITS-1:0] core_program_address_o,
    input  logic [ADDRESS_BITS-1:0] core_pc_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    timed_out_o,
    output logic [ADDRESS_BITS-1:0] halt_pc_o,
    output logic [COUNT_BITS-1:0]   cycle_count_o
);

    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int SW = $clog2(HALT_REPEAT + 1);

    typedef enum logic [1:0] {IDLE, HOLD, START, RUN} state_t;

    state_t                  state_q;
    logic [HW-1:0]           hold_cnt_q;
    logic [SW-1:0]           stable_q;
    logic [SW-1:0]           stable_d;
    logic [ADDRESS_BITS-1:0] last_pc_q;
    logic                    pc_valid_q;
    logic                    core_reset_q;
    logic                    core_start_q;
    logic [ADDRESS_BITS-1:0] prog_addr_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    timed_out_q;
    logic [ADDRESS_BITS-1:0] halt_pc_q;
    logic [COUNT_BITS-1:0]   cycle_count_q;
    logic [COUNT_BITS-1:0]   cycle_count_d;
    logic                    pc_same;
    logic                    halt_hit;
    logic                    timeout_hit;

    always_comb begin
        cycle_count_d = (&cycle_count_q) ? cycle_count_q : cycle_count_q + 1'b1;
        pc_same       = (core_pc_i == last_pc_q);
        stable_d      = stable_q + 1'b1;
        // The comparison that lifts stable to HALT_REPEAT is the halting one.
        halt_hit      = pc_valid_q && pc_same && (stable_q == SW'(HALT_REPEAT - 1));
        timeout_hit   = (cycle_count_d == COUNT_BITS'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            hold_cnt_q    <= '0;
            stable_q      <= '0;
            last_pc_q     <= '0;
            pc_valid_q    <= 1'b0;
            core_reset_q  <= 1'b1;
            core_start_q  <= 1'b0;
            prog_addr_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timed_out_q   <= 1'b0;
            halt_pc_q     <= '0;
            cycle_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go_i) begin
                        prog_addr_q   <= entry_address_i;
                        done_q        <= 1'b0;
                        timed_out_q   <= 1'b0;
                        halt_pc_q     <= '0;
                        cycle_count_q <= '0;
                        hold_cnt_q    <= '0;
                        busy_q        <= 1'b1;
                        state_q       <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == HW'(RESET_CYCLES - 1)) begin
                        core_reset_q <= 1'b0;
                        core_start_q <= 1'b1;
                        state_q      <= START;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                START: begin
                    core_start_q <= 1'b0;
                    stable_q     <= '0;
                    pc_valid_q   <= 1'b0;
                    state_q      <= RUN;
                end
                RUN: begin
                    cycle_count_q <= cycle_count_d;
                    if (!pc_valid_q) begin
                        last_pc_q  <= core_pc_i;
                        pc_valid_q <= 1'b1;
                    end else if (pc_same) begin
                        stable_q <= stable_d;
                    end else begin
                        stable_q  <= '0;
                        last_pc_q <= core_pc_i;
                    end
                    if (halt_hit || timeout_hit) begin
                        done_q       <= halt_hit;
                        timed_out_q  <= !halt_hit;
                        halt_pc_q    <= halt_hit ? core_pc_i : halt_pc_q;
                        busy_q       <= 1'b0;
                        core_reset_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign core_reset_o           = core_reset_q;
    assign core_start_o           = core_start_q;
    assign core_program_address_o = prog_addr_q;
    assign busy_o                 = busy_q;
    assign done_o                 = done_q;
    assign timed_out_o            = timed_out_q;
    assign halt_pc_o              = halt_pc_q;
    assign cycle_count_o          = cycle_count_q;

endmodule
